rf_exec_sequencer: RTL and testbench
====================================

Name: rf_exec_sequencer

Overview:
- Multi-cycle operand-fetch / execute / write-back sequencer that sits directly upstream of the single-port register_file.
- Accepts one decoded instruction per handshake and time-multiplexes the file's single addr/en port: read A, read B, execute, write back.
- Holds operands, ALU result and Z/C flags.
- Sole owner of the register_file en/addr/data_in pins; consumes its combinational data_out.

Parameters:
DATA_W, 8, datapath width (matches register_file word)
ADDR_W, 4, register index width (16 registers)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  sequencer can accept (high only in IDLE)
in_op  in  3  opcode
in_rd  in  ADDR_W  destination register
in_rs1  in  ADDR_W  source A
in_rs2  in  ADDR_W  source B
in_imm  in  DATA_W  immediate (LDI only)
rf_en  out  1  register_file write enable
rf_addr  out  ADDR_W  register_file address
rf_wdata  out  DATA_W  register_file write data
rf_rdata  in  DATA_W  register_file combinational read data
done  out  1  one-cycle pulse, instruction retired
result  out  DATA_W  last ALU result (held)
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MOV (rd<=rs1), 6 LDI (rd<=imm), 7 CMP (flags of rs1-rs2, no write).
- States: IDLE, RD_A, RD_B, EXEC, WB.
- Reset (rst_n=0 at a clk edge): state=IDLE; internal op_a, op_b, result=0; flag_z=0, flag_c=0.
  - Outputs while in IDLE: rf_en=0, rf_addr=0, rf_wdata=0, done=0, in_ready=1.
  - Takes priority over everything, including mid-instruction: no write occurs after the reset edge.
  - register_file contents are untouched.
- Handshake: accept on the edge where in_valid && in_ready; latch op, rd, rs1, rs2, imm. Inputs are ignored when in_ready=0.
- IDLE transitions on accept:
  - LDI -> EXEC, with op_a=imm.
  - All other opcodes -> RD_A.
- RD_A: rf_addr=rs1, rf_en=0; op_a<=rf_rdata at the edge. Next state: MOV -> EXEC, else RD_B.
- RD_B: rf_addr=rs2, rf_en=0; op_b<=rf_rdata at the edge. Next state: EXEC.
- EXEC: result register and flags updated at the edge.
  - CMP: done=1 this cycle; next state IDLE.
  - All other opcodes: next state WB.
- WB: rf_en=1, rf_addr=rd, rf_wdata=result, done=1; next state IDLE (in_ready rises the following cycle).
- rf_* and done are Moore outputs decoded from state plus latched fields. Outside RD_A/RD_B/WB, rf_addr=0 and rf_wdata=0.
- Latency from accept edge to done cycle (cycles): ADD/SUB/AND/OR/XOR 4, CMP 3, MOV 3, LDI 2. Throughput is one instruction per latency+1.
- Arithmetic (8-bit, wrap-around):
  - ADD: {c,r}=a+b.
  - SUB/CMP: r=a-b, c=1 iff a<b (borrow).
  - CMP: computes r but does not update the result register.
  - Logic ops: c<=0.
  - Z=(r==0) for ADD, SUB, AND, OR, XOR, CMP.
  - MOV/LDI: result=op_a; flags unchanged.
- rd==rs1 or rd==rs2: reads complete before WB, so old values are used.
- rs1==rs2: both reads hit the same register; legal.
- in_valid held high through busy cycles is not an error; the next accept occurs in the next IDLE cycle.

Decomposition:
- Shared package rf_exec_pkg:
  - opcode localparams OP_ADD..OP_CMP
  - state encoding ST_IDLE..ST_WB
  - DATA_W/ADDR_W defaults
- One sub-module alu8: purely combinational, (op, a, b) -> (r, c, z). Instantiated in EXEC; the flag update policy stays in the sequencer.

Test Plan:
1. Instantiate with register_file (power-up r[i]=i+1). Reset held 2 cycles -> in_ready=1, rf_en=0, done=0, flags 0. Then ADD rd=0, rs1=2, rs2=3 -> done 4 cycles after accept, WB cycle rf_addr=0, rf_wdata=7, z=0, c=0; read r0 afterwards = 7.
2. Write 0xF0 to r5 and 0x20 to r6 via two LDIs (each done 2 cycles after accept). Then ADD rd=7, rs1=5, rs2=6 -> r7=0x10, c=1, z=0.
3. CMP rs1=4, rs2=4 (both 5) -> done at cycle 3, z=1, c=0, rf_en never asserted, result unchanged. Then SUB rd=1, rs1=1, rs2=2 (2-3) -> r1=0xFF, c=1.
4. MOV rd=9, rs1=9, then XOR rd=9, rs1=9, rs2=9 -> r9 unchanged (10), then r9=0, z=1, c=0. Confirm MOV skips RD_B (latency 3).
5. Start ADD; assert rst_n=0 during RD_B -> next cycle IDLE, in_ready=1, and no rf_en pulse at any time; destination register retains its prior value.
6. in_valid held high with back-to-back LDIs -> accepts spaced exactly 3 cycles apart; in_ready low in EXEC/WB; no instruction lost or duplicated.

Source files
------------

// File: rtl/rf_exec_pkg.sv
// Shared definitions for the register-file execute sequencer: opcodes,
// FSM state encoding and default datapath sizes.
package rf_exec_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_LDI = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_t;

endpackage

// File: rtl/rf_exec_sequencer_alu8.sv
// Purely combinational ALU: result, carry/borrow and zero for one opcode.
// Whether the flags are kept is decided by the sequencer, not here.
module alu8
  import rf_exec_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] r,
  output logic         c,
  output logic         z
);

  logic [W:0] sum;

  always_comb begin
    sum = '0;
    r   = '0;
    c   = 1'b0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        r   = sum[W-1:0];
        c   = sum[W];
      end
      OP_SUB, OP_CMP: begin
        r = a - b;
        c = (a < b);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/rf_exec_sequencer.sv
// Fetch/execute/write-back sequencer that owns the single port of a
// register file: read A, read B, execute, write back, one instruction at a time.
module rf_exec_sequencer
  import rf_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready depends only on state, never on in_valid.
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_z,
  output logic              flag_c,
  output state_t            dbg_state
);

  state_t              state, state_nxt;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]   op_a, op_b, result_q;
  logic                flag_z_q, flag_c_q;
  logic [DATA_W-1:0]   alu_r;
  logic                alu_c, alu_z;
  logic                accept;

  assign accept = in_valid && in_ready;

  alu8 #(.W(DATA_W)) u_alu (
    .op (op_q),
    .a  (op_a),
    .b  (op_b),
    .r  (alu_r),
    .c  (alu_c),
    .z  (alu_z)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rf_en     = 1'b0;
    rf_addr   = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_op == OP_LDI) ? ST_EXEC : ST_RD_A;
      end
      ST_RD_A: begin
        rf_addr   = rs1_q;
        state_nxt = (op_q == OP_MOV) ? ST_EXEC : ST_RD_B;
      end
      ST_RD_B: begin
        rf_addr   = rs2_q;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        // CMP has nothing to write, so it retires straight from EXEC
        if (op_q == OP_CMP) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WB;
        end
      end
      ST_WB: begin
        rf_en     = 1'b1;
        rf_addr   = rd_q;
        rf_wdata  = result_q;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_q     <= OP_ADD;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      result_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
            // LDI has no register read, so the immediate goes straight to A
            if (in_op == OP_LDI) op_a <= in_imm;
          end
        end
        ST_RD_A: op_a <= rf_rdata;
        ST_RD_B: op_b <= rf_rdata;
        ST_EXEC: begin
          if (op_q == OP_MOV || op_q == OP_LDI) begin
            result_q <= alu_r;
          end else if (op_q == OP_CMP) begin
            flag_z_q <= alu_z;
            flag_c_q <= alu_c;
          end else begin
            result_q <= alu_r;
            flag_z_q <= alu_z;
            flag_c_q <= alu_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_rf_exec_sequencer.sv
// Randomised bench for rf_exec_sequencer with a behavioural register file
// and an instruction-level reference model.
module tb_rf_exec_sequencer;
  import rf_exec_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [AW-1:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [DW-1:0] in_imm = '0;
  logic          rf_en;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;
  logic          done;
  logic [DW-1:0] result;
  logic          flag_z, flag_c;
  state_t        dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- register file (power-up r[i] = i+1) ----------------
  logic [DW-1:0] rf_mem [16] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                                  8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
  assign rf_rdata = rf_mem[rf_addr];
  always @(posedge clk) if (rf_en === 1'b1) rf_mem[rf_addr] <= rf_wdata;

  rf_exec_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .rf_en(rf_en), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_rf [16];
  int m_result = 0;
  int m_z = 0;
  int m_c = 0;
  logic [AW+DW-1:0] exp_q[$];

  function automatic int exp_lat(input logic [2:0] op);
    case (op)
      OP_CMP, OP_MOV: return 3;
      OP_LDI:         return 2;
      default:        return 4;
    endcase
  endfunction

  task automatic model_exec(input logic [2:0] op, input logic [AW-1:0] rd,
                            input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                            input logic [DW-1:0] imm);
    int a, b, r;
    a = (op == OP_LDI) ? int'(imm) : m_rf[rs1];
    b = m_rf[rs2];
    case (op)
      OP_ADD: begin r = (a + b) % 256; m_c = (a + b > 255) ? 1 : 0; end
      OP_SUB, OP_CMP: begin r = (a - b + 256) % 256; m_c = (a < b) ? 1 : 0; end
      OP_AND: begin r = a & b; m_c = 0; end
      OP_OR:  begin r = a | b; m_c = 0; end
      OP_XOR: begin r = a ^ b; m_c = 0; end
      default: r = a;
    endcase
    if (op != OP_MOV && op != OP_LDI) m_z = (r == 0) ? 1 : 0;
    if (op != OP_CMP) begin
      m_result = r;
      m_rf[rd] = r;
      exp_q.push_back({rd, DW'(r)});
    end
  endtask

  // ---------------- scoreboard on the write port ----------------
  always @(negedge clk) begin
    if (rf_en === 1'b1) begin
      check("wb_pending", (exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) check("wb_addr_data", {rf_addr, rf_wdata}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks (called on a negedge) ----------------
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [DW-1:0] imm);
    int wait_cyc, lat;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    wait_cyc = 0;
    while (in_ready !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("accept_ready", in_ready, 1'b1);
    model_exec(op, rd, rs1, rs2, imm);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 10) begin
      check("busy_ready", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency_op%0d", op), lat, exp_lat(op));
    check("done_cycle_ready", in_ready, 1'b0);
    @(negedge clk);
    check("done_pulse_width", done, 1'b0);
    check("ready_after", in_ready, 1'b1);
    check("result", result, m_result);
    check("flag_z", flag_z, m_z[0]);
    check("flag_c", flag_c, m_c[0]);
  endtask

  task automatic check_rf(input int idx);
    check($sformatf("rf_r%0d", idx), rf_mem[idx], m_rf[idx]);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, cyc, last;
    logic first, rdy;
    for (int i = 0; i < 16; i++) m_rf[i] = i + 1;

    // reset held two cycles
    rst_n = 1'b0;
    idle_cycles(2);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_rf_en", rf_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_flags", {flag_z, flag_c}, 2'b00);
    check("rst_result", result, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD r0 = r2 + r3 = 3 + 4
    issue(OP_ADD, 4'd0, 4'd2, 4'd3, 8'h00);
    check("t1_r0_is_7", rf_mem[0], 8'd7);
    check_rf(0);

    // 2: LDI, LDI, ADD with carry out
    issue(OP_LDI, 4'd5, 4'd0, 4'd0, 8'hF0);
    issue(OP_LDI, 4'd6, 4'd0, 4'd0, 8'h20);
    issue(OP_ADD, 4'd7, 4'd5, 4'd6, 8'h00);
    check("t2_r7", rf_mem[7], 8'h10);
    check("t2_carry", flag_c, 1'b1);

    // 3: CMP equal operands, then SUB with borrow
    issue(OP_CMP, 4'd0, 4'd4, 4'd4, 8'h00);
    check("t3_cmp_z", flag_z, 1'b1);
    check("t3_cmp_result_kept", result, 8'h10);
    issue(OP_SUB, 4'd1, 4'd1, 4'd2, 8'h00);
    check("t3_r1", rf_mem[1], 8'hFF);

    // 4: MOV onto itself, XOR with itself
    issue(OP_MOV, 4'd9, 4'd9, 4'd0, 8'h00);
    check("t4_r9_kept", rf_mem[9], 8'd10);
    issue(OP_XOR, 4'd9, 4'd9, 4'd9, 8'h00);
    check("t4_r9_zero", rf_mem[9], 8'd0);

    // 5: reset while in RD_B aborts without writing
    in_op = OP_ADD; in_rd = 4'd12; in_rs1 = 4'd1; in_rs2 = 4'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_in_ready", in_ready, 1'b1);
    check("t5_done", done, 1'b0);
    check("t5_flags", {flag_z, flag_c}, 2'b00);
    check("t5_result", result, 0);
    m_result = 0; m_z = 0; m_c = 0;
    rst_n = 1'b1;
    idle_cycles(4);
    check_rf(12);

    // 6: back-to-back LDIs with in_valid held high
    in_op = OP_LDI; in_rd = 4'd10; in_rs1 = '0; in_rs2 = '0; in_imm = 8'($urandom);
    in_valid = 1'b1;
    acc = 0; cyc = 0; last = 0; first = 1'b1;
    while (acc < 4 && cyc < 60) begin
      rdy = in_ready;
      if (!first) check("b2b_ready", rdy, (cyc - last) == 3);
      if (!first) check("b2b_done", done, (cyc - last) == 2);
      if (rdy) begin
        model_exec(in_op, in_rd, in_rs1, in_rs2, in_imm);
        if (!first) check("b2b_spacing", cyc - last, 3);
        last = cyc;
        first = 1'b0;
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (rdy) begin
        in_rd  = 4'(10 + acc);
        in_imm = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check("b2b_count", acc, 4);
    idle_cycles(3);
    for (int i = 10; i < 14; i++) check_rf(i);

    // randomised instructions against the model
    for (int n = 0; n < 60; n++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 8'($urandom));
      idle_cycles($urandom_range(0, 2));
    end
    for (int i = 0; i < 16; i++) check_rf(i);
    check("wb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
